operand_fwd_ctrl: RTL and testbench
===================================

OPERAND_FWD_CTRL -- requirements
Module: operand_fwd_ctrl

Interface
REQ-001 Parameter: REG_AW, 6, register-address width.
REQ-002 Parameter: ZERO_REG, 0, register address that never forwards (hardwired zero).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  decode-stage instruction present.
REQ-006 id_rs, id_rt  input  REG_AW each  decode-stage source register addresses.
REQ-007 id_rd  input  REG_AW  decode-stage destination address.
REQ-008 id_wr_en  input  1  decode-stage instruction writes id_rd.
REQ-009 id_is_load  input  1  decode-stage instruction is a memory load.
REQ-010 flush  input  1  branch taken; kill all tracked instructions.
REQ-011 sel_a, sel_b  output  2 each  select for the downstream 4:1 operand muxes: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 WB hold register.
REQ-012 stall  output  1  hold PC and decode stage this cycle.

Function
REQ-013 Block SHALL track three slots EX, MEM, WB, each {valid, rd, wr_en, is_load}.
REQ-014 On a non-stall, non-flush edge: WB<=MEM, MEM<=EX, EX<={id_valid,id_rd,id_wr_en,id_is_load}; sel_a/sel_b registered in the same edge (latency 1, valid while the instruction sits in EX).
REQ-015 A slot "matches" source s when valid & wr_en & rd==s & s!=ZERO_REG.
REQ-016 Per source, registered select SHALL be: 01 if current EX matches; else 10 if current MEM matches; else 11 if current WB matches; else 00 (youngest producer wins).
REQ-017 If id_valid is 0, next sel_a and sel_b SHALL be 00.
REQ-018 Load-use: FSM states RUN, STALL. In RUN, stall SHALL assert combinationally when id_valid & EX.is_load & EX matches id_rs or id_rt.
REQ-019 On a stall edge: EX<=bubble (valid=0), MEM/WB advance normally, sel outputs<=00, FSM->STALL.
REQ-020 In STALL, stall SHALL be 0 and FSM returns to RUN next edge; the held instruction then forwards from MEM via 10.
REQ-021 Stall SHALL never assert for more than one consecutive cycle per load.
REQ-022 flush SHALL take priority over stall: EX and MEM valid<=0, WB advances from MEM normally, sel<=00, FSM->RUN.
REQ-023 Flush and stall in the same cycle: stall output SHALL still reflect REQ-018 combinationally; state update follows REQ-022.
REQ-024 id_rs==id_rt SHALL yield identical sel_a and sel_b.

Reset
REQ-025 rst_n low SHALL immediately clear all slot valid bits, sel_a=sel_b=00, stall=0, FSM=RUN.
REQ-026 Reset assertion mid-stall SHALL abandon the stall; first post-reset edge behaves as RUN with empty slots.

Structure
REQ-027 Shared package: sel encodings SEL_RF/SEL_EXMEM/SEL_MEMWB/SEL_WBHOLD, FSM state encodings, REG_AW default.
REQ-028 One sub-module fwd_pick SHALL implement REQ-015..017 for one source; instantiated twice (rs, rt).
REQ-029 Target size 120-400 lines RTL; no memories, no multi-cycle paths.

Verification
REQ-030 Back-to-back ALU: add r5 then sub using rs=r5 -> next-cycle sel_a=01, stall=0.
REQ-031 Distance 2 and 3: r7 written, one then two unrelated instrs, reader rt=r7 -> sel_b=10, then sel_b=11 respectively.
REQ-032 Load-use: load r9, next instr rs=r9 -> stall=1 one cycle, EX bubble, then sel_a=10, stall=0 next cycle.
REQ-033 Zero/priority: producers r0 in all slots -> sel 00; r4 in EX and MEM both -> sel 01.
REQ-034 Flush during load-use stall -> slots EX/MEM invalid, FSM RUN, sel 00; async rst_n pulse mid-pipe -> all outputs 00/0 immediately.

Source files
------------

// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared encodings for the operand forwarding controller: mux selects,
// hazard FSM states and the default register-address width.
package operand_fwd_ctrl_pkg;

  localparam int REG_AW_DEFAULT = 6;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RF     = 2'b00;
  localparam sel_t SEL_EXMEM  = 2'b01;
  localparam sel_t SEL_MEMWB  = 2'b10;
  localparam sel_t SEL_WBHOLD = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } fsm_state_e;

  // Youngest producer wins: EX beats MEM beats WB.
  function automatic sel_t pick_sel(input logic ex_hit,
                                    input logic mem_hit,
                                    input logic wb_hit);
    sel_t sel;
    sel = SEL_RF;
    if (ex_hit)       sel = SEL_EXMEM;
    else if (mem_hit) sel = SEL_MEMWB;
    else if (wb_hit)  sel = SEL_WBHOLD;
    return sel;
  endfunction

endpackage

// File: rtl/operand_fwd_ctrl_fwd_pick.sv
// Forwarding select for one decode-stage source operand, compared against
// the three tracked producer slots.
module fwd_pick
  import operand_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEFAULT,
  parameter int ZERO_REG = 0
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              ex_hit,
  output sel_t              sel_nxt
);

  localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(ZERO_REG);

  logic src_live;
  logic mem_hit;
  logic wb_hit;

  // The hardwired-zero register never has a producer worth forwarding.
  assign src_live = (src != ZERO_ADDR);

  assign ex_hit  = ex_wr  && src_live && (ex_rd  == src);
  assign mem_hit = mem_wr && src_live && (mem_rd == src);
  assign wb_hit  = wb_wr  && src_live && (wb_rd  == src);

  assign sel_nxt = id_valid ? pick_sel(ex_hit, mem_hit, wb_hit) : SEL_RF;

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Operand forwarding and load-use hazard control: tracks EX/MEM/WB producers
// and registers the operand mux selects for the instruction entering EX.
module operand_fwd_ctrl
  import operand_fwd_ctrl_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEFAULT,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wr_en;
    logic              is_load;
  } slot_t;

  localparam int EX  = 0;
  localparam int MEM = 1;
  localparam int WB  = 2;

  slot_t      slots [3];
  slot_t      id_slot;
  fsm_state_e state_q;
  fsm_state_e state_d;

  logic ex_wr, mem_wr, wb_wr;
  logic rs_ex_hit, rt_ex_hit;
  logic load_use;
  sel_t sel_a_nxt, sel_b_nxt;

  assign id_slot = '{valid: id_valid, rd: id_rd, wr_en: id_wr_en, is_load: id_is_load};

  assign ex_wr  = slots[EX].valid  && slots[EX].wr_en;
  assign mem_wr = slots[MEM].valid && slots[MEM].wr_en;
  assign wb_wr  = slots[WB].valid  && slots[WB].wr_en;

  fwd_pick #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_pick_rs (
    .id_valid (id_valid),
    .src      (id_rs),
    .ex_wr    (ex_wr),
    .ex_rd    (slots[EX].rd),
    .mem_wr   (mem_wr),
    .mem_rd   (slots[MEM].rd),
    .wb_wr    (wb_wr),
    .wb_rd    (slots[WB].rd),
    .ex_hit   (rs_ex_hit),
    .sel_nxt  (sel_a_nxt)
  );

  fwd_pick #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_pick_rt (
    .id_valid (id_valid),
    .src      (id_rt),
    .ex_wr    (ex_wr),
    .ex_rd    (slots[EX].rd),
    .mem_wr   (mem_wr),
    .mem_rd   (slots[MEM].rd),
    .wb_wr    (wb_wr),
    .wb_rd    (slots[WB].rd),
    .ex_hit   (rt_ex_hit),
    .sel_nxt  (sel_b_nxt)
  );

  // A load in EX cannot supply its data in time for a dependent instruction.
  assign load_use = id_valid && slots[EX].is_load && (rs_ex_hit || rt_ex_hit);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would make the slot shift order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (load_use) state_d = ST_STALL;
        ST_STALL: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // At most one stall cycle per load: the STALL state never requests another.
  always_comb begin
    stall = 1'b0;
    if (state_q == ST_RUN) stall = load_use;
  end

  // NOTE: whole slots are cleared on reset, not just valid, so stale rd bits
  // never reach the compare logic as X in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) slots[i] <= '0;
      sel_a <= SEL_RF;
      sel_b <= SEL_RF;
    end else if (flush) begin
      slots[EX]  <= '0;
      slots[MEM] <= '0;
      slots[WB]  <= slots[MEM];
      sel_a      <= SEL_RF;
      sel_b      <= SEL_RF;
    end else if (stall) begin
      slots[EX]  <= '0;
      slots[MEM] <= slots[EX];
      slots[WB]  <= slots[MEM];
      sel_a      <= SEL_RF;
      sel_b      <= SEL_RF;
    end else begin
      slots[EX]  <= id_slot;
      slots[MEM] <= slots[EX];
      slots[WB]  <= slots[MEM];
      sel_a      <= sel_a_nxt;
      sel_b      <= sel_b_nxt;
    end
  end

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: directed instruction stream with
// hand-computed selects and stall, checked by a negedge monitor.
module tb_operand_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_rs, id_rt, id_rd;
  logic       id_wr_en, id_is_load, flush;
  logic [1:0] sel_a, sel_b;
  logic       stall;

  typedef struct {
    int         step;
    logic [1:0] a;
    logic [1:0] b;
    logic       s;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  operand_fwd_ctrl #(.REG_AW(6), .ZERO_REG(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_wr_en   (id_wr_en),
    .id_is_load (id_is_load),
    .flush      (flush),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .stall      (stall)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one decode-stage cycle and queue what the outputs must show in it.
  task automatic issue(input int n, input logic v, input logic [5:0] rs,
                       input logic [5:0] rt, input logic [5:0] rd,
                       input logic wr, input logic ld, input logic fl,
                       input logic [1:0] ea, input logic [1:0] eb,
                       input logic es);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid   = v;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    id_wr_en   = wr;
    id_is_load = ld;
    flush      = fl;
    e.step = n; e.a = ea; e.b = eb; e.s = es;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check($sformatf("step%0d sel_a", e.step), int'(sel_a), int'(e.a));
        check($sformatf("step%0d sel_b", e.step), int'(sel_b), int'(e.b));
        check($sformatf("step%0d stall", e.step), int'(stall), int'(e.s));
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_wr_en = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    #1;
    check("reset sel_a", int'(sel_a), 0);
    check("reset sel_b", int'(sel_b), 0);
    check("reset stall", int'(stall), 0);
    #2 rst_n = 1'b1;

    //     n  v  rs  rt  rd wr ld fl  sel_a  sel_b  stall
    issue( 1, 1,  1,  2,  5, 1, 0, 0, 2'b00, 2'b00, 1'b0); // add r5
    issue( 2, 1,  5,  3,  6, 1, 0, 0, 2'b00, 2'b00, 1'b0); // sub uses r5
    issue( 3, 1,  1,  1,  7, 1, 0, 0, 2'b01, 2'b00, 1'b0); // r7 producer
    issue( 4, 1,  2,  3,  8, 1, 0, 0, 2'b00, 2'b00, 1'b0);
    issue( 5, 1,  2,  7, 10, 1, 0, 0, 2'b00, 2'b00, 1'b0); // rt=r7 dist 2
    issue( 6, 1,  0,  7,  0, 0, 0, 0, 2'b00, 2'b10, 1'b0); // rt=r7 dist 3
    issue( 7, 1,  3,  3,  0, 1, 0, 0, 2'b00, 2'b11, 1'b0); // r0 producers
    issue( 8, 1,  0,  0,  0, 1, 0, 0, 2'b00, 2'b00, 1'b0);
    issue( 9, 1,  0,  0,  0, 1, 0, 0, 2'b00, 2'b00, 1'b0);
    issue(10, 1,  0,  0,  4, 1, 0, 0, 2'b00, 2'b00, 1'b0); // r4 producer
    issue(11, 1,  4,  4,  4, 1, 0, 0, 2'b00, 2'b00, 1'b0); // r4 again
    issue(12, 1,  4,  4, 11, 1, 0, 0, 2'b01, 2'b01, 1'b0); // r4 in EX+MEM
    issue(13, 1,  1,  2,  9, 1, 1, 0, 2'b01, 2'b01, 1'b0); // load r9
    issue(14, 1,  9,  3, 12, 1, 0, 0, 2'b00, 2'b00, 1'b1); // load-use
    issue(15, 1,  9,  3, 12, 1, 0, 0, 2'b00, 2'b00, 1'b0); // held instr
    issue(16, 1,  1,  1, 13, 1, 1, 0, 2'b10, 2'b00, 1'b0); // load r13
    issue(17, 1,  2, 13, 14, 1, 0, 1, 2'b00, 2'b00, 1'b1); // use + flush
    issue(18, 1, 12, 13,  0, 0, 0, 0, 2'b00, 2'b00, 1'b0);
    issue(19, 0, 12,  0,  0, 0, 0, 0, 2'b11, 2'b00, 1'b0); // idle decode
    issue(20, 1,  1,  1,  5, 1, 0, 0, 2'b00, 2'b00, 1'b0);
    issue(21, 1,  5,  5,  9, 1, 1, 0, 2'b00, 2'b00, 1'b0); // load r9
    issue(22, 1,  9,  5,  2, 1, 0, 0, 2'b01, 2'b01, 1'b1); // stalling

    // Async reset pulse in the middle of the stall cycle, clear of any edge.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset sel_a", int'(sel_a), 0);
    check("midreset sel_b", int'(sel_b), 0);
    check("midreset stall", int'(stall), 0);
    #1 rst_n = 1'b1;

    issue(23, 1,  2,  9,  3, 1, 0, 0, 2'b00, 2'b00, 1'b0);
    issue(24, 0,  0,  0,  0, 0, 0, 0, 2'b01, 2'b00, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
